// File: rtl/metadata_axis_fifo.sv
// Single-clock AXI-Stream FIFO carrying one metadata word per beat with optional
// keep/last/id/dest/user sidebands and an optional store-and-forward frame mode.
module metadata_axis_fifo #(
    parameter int DEPTH                = 4096,
    parameter int DATA_WIDTH           = 8,
    parameter int KEEP_ENABLE          = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH           = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE          = 1,
    parameter int ID_ENABLE            = 0,
    parameter int ID_WIDTH             = 8,
    parameter int DEST_ENABLE          = 0,
    parameter int DEST_WIDTH           = 8,
    parameter int USER_ENABLE          = 1,
    parameter int USER_WIDTH           = 1,
    parameter int FRAME_FIFO           = 0,
    parameter int USER_BAD_FRAME_VALUE = 1,
    parameter int USER_BAD_FRAME_MASK  = 1,
    parameter int DROP_BAD_FRAME       = 0,
    parameter int DROP_WHEN_FULL       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tmetadata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tmetadata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_overflow,
    output logic                  status_bad_frame,
    output logic                  status_good_frame
);

    localparam int WORDS      = (DEPTH + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int ADDR_WIDTH = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam int ENTRIES    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   FULL_XOR  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [USER_WIDTH-1:0] BAD_MASK  = USER_BAD_FRAME_MASK[USER_WIDTH-1:0];
    localparam logic [USER_WIDTH-1:0] BAD_VALUE = USER_BAD_FRAME_VALUE[USER_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] data_mem_q [ENTRIES];
    logic [KEEP_WIDTH-1:0] keep_mem_q [ENTRIES];
    logic                  last_mem_q [ENTRIES];
    logic [ID_WIDTH-1:0]   id_mem_q   [ENTRIES];
    logic [DEST_WIDTH-1:0] dest_mem_q [ENTRIES];
    logic [USER_WIDTH-1:0] user_mem_q [ENTRIES];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, wr_ptr_cur_q, wr_ptr_cur_d, rd_ptr_q, rd_ptr_d;
    logic                  drop_frame_q, drop_frame_d, out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d, bad_frame_q, bad_frame_d, good_frame_q, good_frame_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [DEST_WIDTH-1:0] out_dest_q, out_dest_d;
    logic [USER_WIDTH-1:0] out_user_q, out_user_d;

    logic                  full_s, full_cur_s, full_wr_s, empty_s, s_ready_s, wr_en_s, rd_en_s, bad_in_s, last_in_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
    logic [KEEP_WIDTH-1:0] keep_in_s;
    logic [ID_WIDTH-1:0]   id_in_s;
    logic [DEST_WIDTH-1:0] dest_in_s;
    logic [USER_WIDTH-1:0] user_in_s;

    // Pointer status and sideband masking; disabled fields collapse to constants.
    always_comb begin
        full_s     = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
        full_cur_s = ((wr_ptr_cur_q ^ rd_ptr_q) == FULL_XOR);
        full_wr_s  = ((wr_ptr_cur_q ^ wr_ptr_q) == FULL_XOR);
        empty_s    = (wr_ptr_q == rd_ptr_q);
        wr_addr_s  = wr_ptr_cur_q[ADDR_WIDTH-1:0];
        rd_addr_s  = rd_ptr_q[ADDR_WIDTH-1:0];
        keep_in_s  = (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
        last_in_s  = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
        id_in_s    = (ID_ENABLE != 0) ? s_axis_tid : {ID_WIDTH{1'b0}};
        dest_in_s  = (DEST_ENABLE != 0) ? s_axis_tdest : {DEST_WIDTH{1'b0}};
        user_in_s  = (USER_ENABLE != 0) ? s_axis_tuser : {USER_WIDTH{1'b0}};
        bad_in_s   = (USER_ENABLE != 0) && ((user_in_s & BAD_MASK) == BAD_VALUE);
        // A frame larger than the whole RAM must still be accepted so it can be dropped.
        if (FRAME_FIFO != 0) begin
            s_ready_s = !full_cur_s || full_wr_s || (DROP_WHEN_FULL != 0);
        end else begin
            s_ready_s = !full_s;
        end
    end

    // Write side: pointer advance, frame commit/rollback and status pulses.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        wr_ptr_cur_d = wr_ptr_cur_q;
        drop_frame_d = drop_frame_q;
        overflow_d   = 1'b0;
        bad_frame_d  = 1'b0;
        good_frame_d = 1'b0;
        wr_en_s      = 1'b0;
        if (FRAME_FIFO == 0) begin
            if (s_axis_tvalid && s_ready_s) begin
                wr_en_s      = 1'b1;
                wr_ptr_d     = wr_ptr_q + PTR_ONE;
                wr_ptr_cur_d = wr_ptr_q + PTR_ONE;
            end else begin
                overflow_d = s_axis_tvalid;
            end
        end else if (s_axis_tvalid && s_ready_s) begin
            if (drop_frame_q || full_cur_s || full_wr_s) begin
                drop_frame_d = !last_in_s;
                wr_ptr_cur_d = wr_ptr_q;
                overflow_d   = last_in_s;
            end else begin
                wr_en_s      = 1'b1;
                wr_ptr_cur_d = wr_ptr_cur_q + PTR_ONE;
                if (last_in_s && bad_in_s && (DROP_BAD_FRAME != 0)) begin
                    wr_ptr_cur_d = wr_ptr_q;
                    bad_frame_d  = 1'b1;
                end else if (last_in_s) begin
                    wr_ptr_d     = wr_ptr_cur_q + PTR_ONE;
                    good_frame_d = 1'b1;
                end else begin
                    good_frame_d = 1'b0;
                end
            end
        end else begin
            drop_frame_d = drop_frame_q;
        end
    end

    // Read side: refill the output register whenever it is empty or being consumed.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        out_dest_d  = out_dest_q;
        out_user_d  = out_user_q;
        rd_en_s     = (!out_valid_q || m_axis_tready) && !empty_s;
        if (rd_en_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            out_valid_d = 1'b1;
            out_data_d  = data_mem_q[rd_addr_s];
            out_keep_d  = keep_mem_q[rd_addr_s];
            out_last_d  = last_mem_q[rd_addr_s];
            out_id_d    = id_mem_q[rd_addr_s];
            out_dest_d  = dest_mem_q[rd_addr_s];
            out_user_d  = user_mem_q[rd_addr_s];
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Storage RAM, written at the speculative pointer.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            data_mem_q[wr_addr_s] <= s_axis_tmetadata;
            keep_mem_q[wr_addr_s] <= keep_in_s;
            last_mem_q[wr_addr_s] <= last_in_s;
            id_mem_q[wr_addr_s]   <= id_in_s;
            dest_mem_q[wr_addr_s] <= dest_in_s;
            user_mem_q[wr_addr_s] <= user_in_s;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {(ADDR_WIDTH+1){1'b0}};
            wr_ptr_cur_q <= {(ADDR_WIDTH+1){1'b0}};
            rd_ptr_q     <= {(ADDR_WIDTH+1){1'b0}};
            drop_frame_q <= 1'b0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            bad_frame_q  <= 1'b0;
            good_frame_q <= 1'b0;
            out_data_q   <= {DATA_WIDTH{1'b0}};
            out_keep_q   <= {KEEP_WIDTH{1'b0}};
            out_last_q   <= 1'b0;
            out_id_q     <= {ID_WIDTH{1'b0}};
            out_dest_q   <= {DEST_WIDTH{1'b0}};
            out_user_q   <= {USER_WIDTH{1'b0}};
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_ptr_cur_q <= wr_ptr_cur_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_frame_q <= drop_frame_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            bad_frame_q  <= bad_frame_d;
            good_frame_q <= good_frame_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_id_q     <= out_id_d;
            out_dest_q   <= out_dest_d;
            out_user_q   <= out_user_d;
        end
    end

    assign s_axis_tready     = s_ready_s;
    assign m_axis_tvalid     = out_valid_q;
    assign m_axis_tmetadata  = out_data_q;
    assign m_axis_tkeep      = out_keep_q;
    assign m_axis_tlast      = out_last_q;
    assign m_axis_tid        = out_id_q;
    assign m_axis_tdest      = out_dest_q;
    assign m_axis_tuser      = out_user_q;
    assign status_overflow   = overflow_q;
    assign status_bad_frame  = bad_frame_q;
    assign status_good_frame = good_frame_q;

endmodule

// File: tb/tb_metadata_axis_fifo.sv
// Self-checking bench: directed scenarios plus a randomized queue-model scoreboard,
// one plain-stream instance and one frame-mode instance.
module tb_metadata_axis_fifo;
    localparam int DW  = 10;
    localparam int CAP = 17; // 16-entry RAM (DEPTH=16, KEEP_WIDTH=1) plus the output register

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] s_data, m_data, f_s_data, f_m_data;
    logic [0:0]    s_keep, m_keep, s_user, m_user, f_s_keep, f_m_keep, f_s_user, f_m_user;
    logic [7:0]    s_id, s_dest, m_id, m_dest, f_s_id, f_s_dest, f_m_id, f_m_dest;
    logic s_valid, s_ready, s_last, m_valid, m_ready, m_last, ovf, badf, goodf;
    logic f_s_valid, f_s_ready, f_s_last, f_m_valid, f_m_ready, f_m_last, f_ovf, f_badf, f_goodf;

    int total = 0;
    int bad   = 0;

    metadata_axis_fifo #(.DEPTH(16), .DATA_WIDTH(DW), .KEEP_WIDTH(1), .FRAME_FIFO(0)) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tmetadata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tid(s_id),
        .s_axis_tdest(s_dest), .s_axis_tuser(s_user),
        .m_axis_tmetadata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tid(m_id),
        .m_axis_tdest(m_dest), .m_axis_tuser(m_user),
        .status_overflow(ovf), .status_bad_frame(badf), .status_good_frame(goodf)
    );

    metadata_axis_fifo #(.DEPTH(16), .DATA_WIDTH(DW), .KEEP_WIDTH(1), .FRAME_FIFO(1)) u_frm (
        .clk(clk), .rst(rst),
        .s_axis_tmetadata(f_s_data), .s_axis_tkeep(f_s_keep), .s_axis_tvalid(f_s_valid),
        .s_axis_tready(f_s_ready), .s_axis_tlast(f_s_last), .s_axis_tid(f_s_id),
        .s_axis_tdest(f_s_dest), .s_axis_tuser(f_s_user),
        .m_axis_tmetadata(f_m_data), .m_axis_tkeep(f_m_keep), .m_axis_tvalid(f_m_valid),
        .m_axis_tready(f_m_ready), .m_axis_tlast(f_m_last), .m_axis_tid(f_m_id),
        .m_axis_tdest(f_m_dest), .m_axis_tuser(f_m_user),
        .status_overflow(f_ovf), .status_bad_frame(f_badf), .status_good_frame(f_goodf)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid: got %b want 0", m_valid); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_tready: got %b want 1", s_ready); end
        total++; if ({ovf, badf, goodf} !== 3'b000) begin bad++; $display("FAIL reset_status: got %b want 000", {ovf, badf, goodf}); end
        total++; if (m_data !== 10'h000) begin bad++; $display("FAIL reset_m_data: got %h want 000", m_data); end
        total++; if ({f_m_valid, f_s_ready, f_goodf} !== 3'b010) begin bad++; $display("FAIL reset_frame: got %b want 010", {f_m_valid, f_s_ready, f_goodf}); end
        rst = 1'b0;
    endtask

    task automatic test_latency();
        m_ready = 1'b0; s_valid = 1'b1; s_data = 10'h155;
        tick();
        s_valid = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got %b want 0", m_valid); end
        tick();
        total++; if ({m_valid, m_data} !== {1'b1, 10'h155}) begin bad++; $display("FAIL lat_present: got %b/%h want 1/155", m_valid, m_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({m_valid, m_data} !== {1'b1, 10'h155}) begin bad++; $display("FAIL lat_hold: got %b/%h want 1/155", m_valid, m_data); end
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL lat_consumed: got %b want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            total++; if ({m_valid, m_data} !== {1'b1, DW'(k)}) begin bad++; $display("FAIL b2b_beat%0d: got %b/%h want 1/%h", k, m_valid, m_data, DW'(k)); end
            tick();
        end
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", m_valid); end
    endtask

    task automatic test_fill_overflow();
        int n_acc = 0;
        m_ready = 1'b0; s_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            s_data = DW'(n_acc + 1);
            if (!s_ready) break;
            tick();
            n_acc++;
        end
        total++; if (n_acc != CAP) begin bad++; $display("FAIL fill_count: got %0d want %0d", n_acc, CAP); end
        total++; if ({s_ready, ovf} !== 2'b00) begin bad++; $display("FAIL fill_full: got %b want 00", {s_ready, ovf}); end
        tick();
        s_valid = 1'b0;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL fill_ovf_pulse: got %b want 1", ovf); end
        tick();
        total++; if ({ovf, s_ready} !== 2'b00) begin bad++; $display("FAIL fill_ovf_once: got %b want 00", {ovf, s_ready}); end
        m_ready = 1'b1;
        for (int k = 1; k <= CAP; k++) begin
            total++; if ({m_valid, m_data} !== {1'b1, DW'(k)}) begin bad++; $display("FAIL fill_drain%0d: got %b/%h want 1/%h", k, m_valid, m_data, DW'(k)); end
            tick();
        end
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL fill_empty: got %b want 0", m_valid); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp_l [3];
        exp_l[0] = 10'h022; exp_l[1] = 10'h023; exp_l[2] = 10'h024;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = DW'(10'h021 + i);
            tick();
        end
        s_valid = 1'b0;
        tick();
        total++; if ({m_valid, m_data} !== {1'b1, 10'h021}) begin bad++; $display("FAIL simul_head0: got %b/%h want 1/021", m_valid, m_data); end
        m_ready = 1'b1; s_valid = 1'b1; s_data = 10'h024;
        tick();
        m_ready = 1'b0; s_valid = 1'b0;
        tick();
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++; if ({m_valid, m_data} !== {1'b1, exp_l[k]}) begin bad++; $display("FAIL simul_order%0d: got %b/%h want 1/%h", k, m_valid, m_data, exp_l[k]); end
            tick();
        end
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL simul_empty: got %b want 0", m_valid); end
    endtask

    task automatic test_reset_mid_stream();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = DW'(10'h040 + i);
            tick();
        end
        s_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({m_valid, s_ready} !== 2'b01) begin bad++; $display("FAIL rstmid_flags: got %b want 01", {m_valid, s_ready}); end
        total++; if ({ovf, badf, goodf} !== 3'b000) begin bad++; $display("FAIL rstmid_status: got %b want 000", {ovf, badf, goodf}); end
        s_valid = 1'b1; s_data = 10'h03A;
        tick();
        s_valid = 1'b0;
        tick();
        total++; if ({m_valid, m_data} !== {1'b1, 10'h03A}) begin bad++; $display("FAIL rstmid_first: got %b/%h want 1/03a", m_valid, m_data); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_only: got %b want 0", m_valid); end
    endtask

    task automatic test_random();
        logic [DW+2:0] q [$];
        logic ovf_exp = 1'b0;
        int stall = 0;
        for (int c = 0; c < 640 && (c < 600 || q.size() > 0); c++) begin
            if (c < 600) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = DW'($urandom);
                s_keep  = 1'($urandom);
                s_last  = 1'($urandom);
                s_user  = 1'($urandom);
                m_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            end else begin
                s_valid = 1'b0;
                m_ready = 1'b1;
            end
            total++; if (ovf !== ovf_exp) begin bad++; $display("FAIL rand_overflow c=%0d: got %b want %b", c, ovf, ovf_exp); end
            if (q.size() == 0) begin
                total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rand_spurious c=%0d: got tvalid %b want 0", c, m_valid); end
                stall = 0;
            end else if (m_valid) begin
                total++; if ({m_last, m_user, m_keep, m_data} !== q[0]) begin bad++; $display("FAIL rand_data c=%0d: got %h want %h", c, {m_last, m_user, m_keep, m_data}, q[0]); end
                total++; if ({m_id, m_dest} !== 16'h0000) begin bad++; $display("FAIL rand_sideband c=%0d: got %h want 0000", c, {m_id, m_dest}); end
                stall = 0;
            end else begin
                stall++;
                total++; if (stall > 1) begin bad++; $display("FAIL rand_latency c=%0d: got %0d idle cycles want <=1", c, stall); end
            end
            if (m_valid && m_ready && q.size() > 0) void'(q.pop_front());
            if (s_valid && s_ready) q.push_back({s_last, s_user, s_keep, s_data});
            ovf_exp = s_valid && !s_ready;
            total++; if (q.size() > CAP) begin bad++; $display("FAIL rand_capacity c=%0d: got %0d stored want <=%0d", c, q.size(), CAP); end
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d left want 0", q.size()); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rand_final_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_frame();
        f_m_ready = 1'b0; f_s_user = 1'b0; f_s_keep = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_s_valid = 1'b1; f_s_data = DW'(10'h101 + i); f_s_last = (i == 2);
            tick();
            if (i < 2) begin
                total++; if ({f_m_valid, f_goodf} !== 2'b00) begin bad++; $display("FAIL frame_hold%0d: got %b want 00", i, {f_m_valid, f_goodf}); end
            end
        end
        f_s_valid = 1'b0; f_s_last = 1'b0;
        total++; if ({f_goodf, f_badf, f_ovf} !== 3'b100) begin bad++; $display("FAIL frame_good_pulse: got %b want 100", {f_goodf, f_badf, f_ovf}); end
        tick();
        total++; if ({f_goodf, f_m_valid} !== 2'b01) begin bad++; $display("FAIL frame_good_once: got %b want 01", {f_goodf, f_m_valid}); end
        f_m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if ({f_m_valid, f_m_last, f_m_data} !== {1'b1, (i == 2), DW'(10'h101 + i)}) begin bad++; $display("FAIL frame_beat%0d: got %b/%b/%h want 1/%b/%h", i, f_m_valid, f_m_last, f_m_data, (i == 2), DW'(10'h101 + i)); end
            total++; if ({f_m_keep, f_m_user, f_m_id, f_m_dest} !== {1'b1, 1'b0, 16'h0000}) begin bad++; $display("FAIL frame_side%0d: got %h", i, {f_m_keep, f_m_user, f_m_id, f_m_dest}); end
            tick();
        end
        f_m_ready = 1'b0;
        total++; if (f_m_valid !== 1'b0) begin bad++; $display("FAIL frame_end: got %b want 0", f_m_valid); end
    endtask

    initial begin
        rst = 1'b1;
        s_data = '0; s_keep = 1'b1; s_valid = 1'b0; s_last = 1'b1; s_id = 8'h00; s_dest = 8'h00; s_user = 1'b0; m_ready = 1'b0;
        f_s_data = '0; f_s_keep = 1'b1; f_s_valid = 1'b0; f_s_last = 1'b0; f_s_id = 8'h00; f_s_dest = 8'h00; f_s_user = 1'b0; f_m_ready = 1'b0;
        tick();
        test_reset();
        test_latency();
        test_back_to_back();
        test_fill_overflow();
        test_simultaneous();
        test_reset_mid_stream();
        test_random();
        test_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
